// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        kill;
    } inflight_entry_t;

endpackage

// File: rtl/sync_fifo_flush.sv
// Synchronous FIFO with flush and a per-entry kill flag that can be set on every entry at once.
module sync_fifo_flush #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    input  logic             kill_all,
    output logic [WIDTH-1:0] head_data,
    output logic             head_kill,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] kill_q;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    assign head_data = mem[rd_ptr];
    assign head_kill = kill_q[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            kill_q <= '0;
        end else begin
            if (kill_all) begin
                kill_q <= '1;
            end
            if (do_push) begin
                kill_q[wr_ptr] <= 1'b0;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: fetch PC, credit-limited imem requests, in-flight PC queue,
// instruction buffer towards decode, and redirect flush/kill handling.
module fetch_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] fetch_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc_plus_4
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam int FW = $bits(fetch_entry_t);

    logic [CW-1:0]   inflight_cnt;
    logic [CW-1:0]   buf_cnt;
    logic [CW:0]     occupancy;
    logic            credit_ok;
    logic            req_fire;
    logic            rsp_accept;
    logic            buf_push;
    logic            buf_pop;
    logic [31:0]     inflight_head_pc;
    logic            inflight_head_kill;
    logic            inflight_full;
    logic            inflight_empty;
    inflight_entry_t inflight_head;
    fetch_entry_t    buf_in;
    logic [FW-1:0]   buf_head_bits;
    fetch_entry_t    buf_head;
    logic            buf_head_kill;
    logic            buf_full;
    logic            buf_empty;
    logic            unused_sigs;

    // Killed entries still hold credit until their responses drain.
    assign occupancy = {1'b0, inflight_cnt} + {1'b0, buf_cnt};
    assign credit_ok = occupancy < (CW+1)'(BUF_DEPTH);

    assign imem_req_valid = !rst && !redirect_valid && credit_ok;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
        end else if (req_fire) begin
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    sync_fifo_flush #(
        .WIDTH (32),
        .DEPTH (BUF_DEPTH),
        .CW    (CW)
    ) u_inflight_q (
        .clk       (clk),
        .rst       (rst),
        .push      (req_fire),
        .push_data (fetch_pc),
        .pop       (rsp_accept),
        .flush     (1'b0),
        .kill_all  (redirect_valid),
        .head_data (inflight_head_pc),
        .head_kill (inflight_head_kill),
        .count     (inflight_cnt),
        .full      (inflight_full),
        .empty     (inflight_empty)
    );

    assign inflight_head = '{pc: inflight_head_pc, kill: inflight_head_kill};

    assign rsp_accept = imem_rsp_valid && !inflight_empty;
    assign buf_push   = rsp_accept && !inflight_head.kill && !redirect_valid;
    assign buf_pop    = if_valid && if_ready;
    assign buf_in     = '{pc: inflight_head.pc, instr: imem_rsp_data};

    sync_fifo_flush #(
        .WIDTH (FW),
        .DEPTH (BUF_DEPTH),
        .CW    (CW)
    ) u_instr_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (buf_push),
        .push_data (buf_in),
        .pop       (buf_pop),
        .flush     (redirect_valid),
        .kill_all  (1'b0),
        .head_data (buf_head_bits),
        .head_kill (buf_head_kill),
        .count     (buf_cnt),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    assign buf_head     = buf_head_bits;
    assign if_valid     = !buf_empty;
    assign if_pc        = buf_head.pc;
    assign if_instr     = if_valid ? buf_head.instr : INSTR_NOP;
    assign if_pc_plus_4 = if_pc + 32'd4;

    assign unused_sigs = ^{inflight_full, buf_head_kill, buf_full, redirect_pc[1:0]};

    a_rsp_without_req : assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> !inflight_empty);

    a_rsp_into_full_buf : assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> !buf_full);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory model with per-request epochs feeds a decode scoreboard.
module tb_fetch_stage;
    import if_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] if_pc_plus_4;

    fetch_stage #(.RESET_PC(RST_PC), .BUF_DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_pc       (fetch_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_pc_plus_4   (if_pc_plus_4)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A00_0013;
    endfunction

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          wait_c;
    } mem_txn_t;

    mem_txn_t     pend[$];
    fetch_entry_t exp_q[$];
    int           lat   = 1;
    int           epoch = 0;
    logic         first_armed = 1'b0;
    logic [31:0]  first_exp   = '0;

    // Memory: records accepted requests, answers in order after lat cycles, and
    // predicts which responses survive to decode (same epoch, no redirect that cycle).
    initial begin
        mem_txn_t t;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend.delete();
                exp_q.delete();
                epoch++;
            end else begin
                if (imem_rsp_valid && pend.size() > 0) begin
                    t = pend.pop_front();
                    if (t.epoch == epoch && !redirect_valid)
                        exp_q.push_back('{pc: t.addr, instr: instr_of(t.addr)});
                end
                if (redirect_valid) epoch++;
                if (imem_req_valid && imem_req_ready)
                    pend.push_back('{addr: imem_req_addr, epoch: epoch, wait_c: lat});
            end
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            foreach (pend[i]) if (pend[i].wait_c > 0) pend[i].wait_c--;
            if (pend.size() > 0 && pend[0].wait_c == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = instr_of(pend[0].addr);
            end
        end
    end

    // Monitor: request address sequence and decode scoreboard.
    initial begin
        logic [31:0]  exp_addr;
        fetch_entry_t e;
        exp_addr = RST_PC;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_addr = RST_PC;
            end else begin
                if (redirect_valid) begin
                    check("no_req_on_redirect", 32'(imem_req_valid), 32'd0);
                    exp_addr = {redirect_pc[31:2], 2'b00};
                end else if (imem_req_valid && imem_req_ready) begin
                    check("req_addr", imem_req_addr, exp_addr);
                    exp_addr = exp_addr + 32'd4;
                end
                if (if_valid && if_ready) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_decode: got pc %h, expected no instruction", if_pc);
                    end else begin
                        e = exp_q.pop_front();
                        check("if_pc", if_pc, e.pc);
                        check("if_instr", if_instr, e.instr);
                        check("if_pc_plus_4", if_pc_plus_4, e.pc + 32'd4);
                    end
                    if (first_armed) begin
                        check("first_pc", if_pc, first_exp);
                        first_armed = 1'b0;
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        imem_req_ready = 1'b0;
        if_ready       = 1'b1;
        cyc(8);
    endtask

    initial begin
        int n_req;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; if_ready = 1'b0;
        cyc(2);
        @(negedge clk);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_fetch_pc", fetch_pc, RST_PC);

        // Stall: decode not ready, only BUF_DEPTH fetches may issue.
        cyc(1);
        rst = 1'b0; lat = 1; imem_req_ready = 1'b1; if_ready = 1'b0;
        first_exp = 32'h0; first_armed = 1'b1;
        n_req = 0;
        repeat (8) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) n_req++;
        end
        check("stall_req_count", 32'(n_req), 32'd2);
        repeat (3) begin
            @(negedge clk);
            check("stall_req_valid", 32'(imem_req_valid), 32'd0);
            check("stall_if_valid", 32'(if_valid), 32'd1);
            check("stall_if_pc", if_pc, 32'h0);
            check("stall_if_instr", if_instr, instr_of(32'h0));
            check("stall_fetch_pc", fetch_pc, 32'h8);
        end
        cyc(1);
        if_ready = 1'b1;
        cyc(20);
        drain();

        // Redirect with two fetches in flight (3-cycle memory).
        lat = 3; imem_req_ready = 1'b1;
        cyc(2);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        cyc(1);
        redirect_valid = 1'b0; first_exp = 32'h100; first_armed = 1'b1;
        cyc(16);
        drain();

        // Redirect coinciding with a response and a decode pop.
        lat = 1; imem_req_ready = 1'b1;
        cyc(2);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        check("coinc_rsp_valid", 32'(imem_rsp_valid), 32'd1);
        check("coinc_if_valid", 32'(if_valid), 32'd1);
        cyc(1);
        redirect_valid = 1'b0; first_exp = 32'h100; first_armed = 1'b1;
        @(negedge clk);
        check("post_redirect_if_valid", 32'(if_valid), 32'd0);
        check("post_redirect_req_valid", 32'(imem_req_valid), 32'd1);
        check("post_redirect_req_addr", imem_req_addr, 32'h100);
        cyc(12);
        drain();

        // Two redirects with one idle cycle between, 3-cycle memory.
        lat = 3; imem_req_ready = 1'b1;
        cyc(1);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        cyc(1);
        redirect_valid = 1'b0;
        cyc(1);
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        cyc(1);
        redirect_valid = 1'b0; first_exp = 32'h300; first_armed = 1'b1;
        cyc(20);
        drain();

        // Misaligned redirect near the top of the address space, then wrap.
        lat = 1; imem_req_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        cyc(1);
        redirect_valid = 1'b0; first_exp = 32'hFFFF_FFFC; first_armed = 1'b1;
        @(negedge clk);
        check("wrap_fetch_pc", fetch_pc, 32'hFFFF_FFFC);
        check("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        cyc(10);

        // Reset in the middle of streaming.
        rst = 1'b1;
        @(negedge clk);
        check("midrst_req_valid", 32'(imem_req_valid), 32'd0);
        cyc(1);
        @(negedge clk);
        check("midrst_if_valid", 32'(if_valid), 32'd0);
        check("midrst_fetch_pc", fetch_pc, RST_PC);
        cyc(1);
        rst = 1'b0; first_exp = RST_PC; first_armed = 1'b1;
        @(negedge clk);
        check("after_rst_req_valid", 32'(imem_req_valid), 32'd1);
        check("after_rst_req_addr", imem_req_addr, RST_PC);
        cyc(10);
        drain();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("first_pc_seen", 32'(first_armed), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly downstream of the PC-select mux.
- Holds the architectural fetch PC and issues in-order requests to instruction memory with a valid/ready handshake.
- Buffers returned instructions with their PCs and presents them to decode through a valid/ready interface.
- On a control-flow change, loads the mux's target, flushes buffered and in-flight wrong-path instructions, and restarts fetch.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- BUF_DEPTH, 2, instruction buffer entries; also the maximum number of in-flight plus buffered fetches (power of 2, ≥2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- redirect_valid  in  1  control-flow change this cycle (mux selected a non-sequential target).
- redirect_pc  in  32  target PC from the PC-select mux.
- fetch_pc  out  32  current fetch PC register; feeds the PC+4 and PC+imm adders.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  32  fetch address.
- imem_rsp_valid  in  1  response valid; in order, one cycle wide, no backpressure.
- imem_rsp_data  in  32  instruction word.
- if_valid  out  1  instruction available to decode.
- if_ready  in  1  decode accepts the instruction.
- if_pc  out  32  PC of the presented instruction.
- if_instr  out  32  presented instruction.
- if_pc_plus_4  out  32  if_pc + 4, modulo 2^32.

Behaviour:
- Reset: fetch_pc=RESET_PC; in-flight and buffer counts=0; all kill bits clear; if_valid=0; imem_req_valid=0 during the reset cycle.
- Credit: credit_ok = (inflight_cnt + buf_cnt) < BUF_DEPTH. Killed in-flight entries still consume credit until their responses return.
- Request logic is combinational:
  - imem_req_valid = !rst && !redirect_valid && credit_ok.
  - imem_req_addr = fetch_pc.
  - The request may be withdrawn when its valid drops; memory must tolerate this.
- Request handshake (valid && ready):
  - fetch_pc <= fetch_pc + 4, wrapping modulo 2^32.
  - Push {pc, kill=0} into the in-flight PC queue; inflight_cnt++.
- Response (imem_rsp_valid):
  - Pop the head of the in-flight queue; inflight_cnt--.
  - If the entry's kill bit is clear and no redirect occurs this cycle, push {pc, imem_rsp_data} into the instruction buffer. Otherwise discard it.
  - A response with an empty in-flight queue is a protocol error: assertion in simulation; ignored in RTL.
- Decode handshake (if_valid && if_ready): pop the buffer head.
  - if_valid = (buf_cnt != 0).
  - if_pc, if_instr and if_pc_plus_4 show the buffer head and stay stable while if_valid && !if_ready.
- Latency: a response in cycle N is visible on if_valid in cycle N+1. The buffer is registered with no bypass.
- Redirect (redirect_valid=1), with priority over every other event in the same cycle:
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - Instruction buffer flushed (buf_cnt <= 0). A decode pop in the same cycle is irrelevant.
  - All in-flight entries get kill=1, including any popped in this cycle.
  - No request is issued this cycle.
  - Fetch resumes at the new PC next cycle.
- Back-to-back redirects: each one re-kills all in-flight entries. Kill bits are sticky until popped, so repeated redirects cannot alias.
- Full buffer: credit prevents a response from arriving with the buffer full. Assert this in simulation.
- Wrap-around: PC 32'hFFFF_FFFC + 4 = 32'h0000_0000. Queue pointers wrap modulo BUF_DEPTH.
- Simultaneous push and pop on the buffer in the same cycle: buf_cnt is unchanged, and order is preserved.

Decomposition:
- Shared package if_pkg:
  - Constants: RESET_PC default, INSTR_NOP=32'h0000_0013.
  - Typedefs: fetch_entry_t {pc[31:0], instr[31:0]}; inflight_entry_t {pc[31:0], kill}.
- Sub-module sync_fifo_flush: generic synchronous FIFO with push, pop, flush, count, full and empty.
  - Instance 1 is the in-flight queue. It needs a kill-all input (sets kill on every entry) rather than a flush, since killed entries must remain until their responses return.
  - Instance 2 is the instruction buffer, which uses flush.
- Top level holds the PC register, credit logic and redirect control.

Test Plan:
- Reset then imem_req_ready=1 with 1-cycle responses → addresses 0x0, 0x4, 0x8…; decode sees if_pc 0x0/0x4/0x8 with matching instructions; if_pc_plus_4 0x4/0x8/0xC.
- Hold if_ready=0 → at most 2 requests issue, then imem_req_valid=0; buffer stays full and stable. Release if_ready → fetch resumes at 0x8.
- Redirect to 0x100 with 2 fetches in flight → both responses dropped; next request addr 0x100; first if_pc = 0x100.
- Redirect coinciding with an imem response and a decode pop → response dropped, buffer empty the next cycle, next request 0x100.
- Two redirects 1 cycle apart (0x200 then 0x300) with a 3-cycle memory latency → no instructions from 0x4 or 0x200 reach decode; first if_pc = 0x300.
- Redirect to 0xFFFF_FFFE → request addr 0xFFFF_FFFC, next addr 0x0000_0000; rst asserted mid-stream → if_valid=0, next request addr RESET_PC.
